// File: rtl/xdma_irq_ctrl.sv
// xdma_irq_ctrl: per-vector usr_irq_req/usr_irq_ack sequencer for the XDMA core.
// Latches event pulses into pending bits, holds each request until it is
// acked or times out, then enforces a gap before that vector may request again.
// Ports:
//   axi_aclk, axi_aresetn : clock, async active-low reset
//   irq_event  [WIRQ]     : per-vector event, sets pending
//   irq_mask   [WIRQ]     : blocks new requests (pending still accumulates)
//   usr_irq_req[WIRQ]     : registered request to the XDMA core
//   usr_irq_ack[WIRQ]     : ack pulses from the XDMA core
//   irq_pending[WIRQ]     : pending bits
//   irq_busy   [WIRQ]     : vector in REQ or GAP
//   irq_err    [WIRQ]     : sticky ack-timeout flags, cleared by err_clr
//   irq_sent_cnt[CNT_W]   : saturating count of acknowledged requests
module xdma_irq_ctrl #(
   parameter int WIRQ        = 2,
   parameter int GAP_CYC     = 4,
   parameter int TIMEOUT_CYC = 1024,
   parameter int CNT_W       = 16
) (
   input  logic             axi_aclk,
   input  logic             axi_aresetn,
   input  logic [WIRQ-1:0]  irq_event,
   input  logic [WIRQ-1:0]  irq_mask,
   output logic [WIRQ-1:0]  usr_irq_req,
   input  logic [WIRQ-1:0]  usr_irq_ack,
   output logic [WIRQ-1:0]  irq_pending,
   output logic [WIRQ-1:0]  irq_busy,
   output logic [WIRQ-1:0]  irq_err,
   input  logic [WIRQ-1:0]  err_clr,
   output logic [CNT_W-1:0] irq_sent_cnt
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      GAP  = 2'd2
   } state_e;

   // One timer per vector serves both the ack timeout and the gap count.
   localparam int MAXC = (TIMEOUT_CYC > GAP_CYC) ? TIMEOUT_CYC : GAP_CYC;
   localparam int TW   = (MAXC > 1) ? $clog2(MAXC) : 1;
   localparam int TO_L = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;
   localparam logic [TW-1:0] TO_LAST  = TW'(TO_L);
   localparam logic [TW-1:0] GAP_LAST = TW'(GAP_CYC - 1);
   localparam int SW = CNT_W + 5;
   localparam logic [SW-1:0] SAT = {5'd0, {CNT_W{1'b1}}};

   state_e           state_q [WIRQ];
   state_e           state_d [WIRQ];
   logic [TW-1:0]    tmr_q   [WIRQ];
   logic [TW-1:0]    tmr_d   [WIRQ];
   logic [WIRQ-1:0]  pend_q, pend_d;
   logic [WIRQ-1:0]  err_q, err_d;
   logic [WIRQ-1:0]  req_q, req_d;
   logic [WIRQ-1:0]  busy_q, busy_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [4:0]       inc;
   logic [SW-1:0]    sum;
   logic             take;

   always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
      if (!axi_aresetn) begin
         for (int i = 0; i < WIRQ; i++) begin
            state_q[i] <= IDLE;
            tmr_q[i]   <= '0;
         end
         pend_q <= '0;
         err_q  <= '0;
         req_q  <= '0;
         busy_q <= '0;
         cnt_q  <= '0;
      end else begin
         for (int i = 0; i < WIRQ; i++) begin
            state_q[i] <= state_d[i];
            tmr_q[i]   <= tmr_d[i];
         end
         pend_q <= pend_d;
         err_q  <= err_d;
         req_q  <= req_d;
         busy_q <= busy_d;
         cnt_q  <= cnt_d;
      end
   end

   always_comb begin
      pend_d = pend_q;
      err_d  = err_q & ~err_clr;
      req_d  = '0;
      busy_d = '0;
      inc    = '0;
      take   = 1'b0;
      for (int i = 0; i < WIRQ; i++) begin
         state_d[i] = state_q[i];
         tmr_d[i]   = tmr_q[i];
         take       = 1'b0;
         unique case (state_q[i])
            IDLE: begin
               if (pend_q[i] && !irq_mask[i]) begin
                  state_d[i] = REQ;
                  tmr_d[i]   = '0;
                  take       = 1'b1;
               end
            end
            REQ: begin
               if (usr_irq_ack[i]) begin
                  state_d[i] = GAP;
                  tmr_d[i]   = '0;
                  inc        = inc + 5'd1;
               end else if (TIMEOUT_CYC != 0 && tmr_q[i] == TO_LAST) begin
                  state_d[i] = GAP;
                  tmr_d[i]   = '0;
                  err_d[i]   = 1'b1;
               end else begin
                  tmr_d[i] = tmr_q[i] + 1'b1;
               end
            end
            GAP: begin
               if (tmr_q[i] == GAP_LAST) begin
                  state_d[i] = IDLE;
                  tmr_d[i]   = '0;
               end else begin
                  tmr_d[i] = tmr_q[i] + 1'b1;
               end
            end
            default: begin
               state_d[i] = IDLE;
               tmr_d[i]   = '0;
            end
         endcase
         // A new event in the capture cycle keeps the bit set.
         pend_d[i] = (pend_q[i] & ~take) | irq_event[i];
         req_d[i]  = (state_d[i] == REQ);
         busy_d[i] = (state_d[i] != IDLE);
      end
      sum   = {5'd0, cnt_q} + {{(SW-5){1'b0}}, inc};
      cnt_d = (sum > SAT) ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
   end

   assign usr_irq_req  = req_q;
   assign irq_pending  = pend_q;
   assign irq_busy     = busy_q;
   assign irq_err      = err_q;
   assign irq_sent_cnt = cnt_q;

endmodule

// File: tb/tb_xdma_irq_ctrl.sv
// tb_xdma_irq_ctrl: directed self-checking bench for xdma_irq_ctrl.
// WIRQ=2, GAP_CYC=4, TIMEOUT_CYC=8, CNT_W=2 (saturates at 3).
module tb_xdma_irq_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [1:0] ev, msk, req, ack, pend, busy, err, clr;
   logic [1:0] cnt;

   int n_chk  = 0;
   int n_pass = 0;

   xdma_irq_ctrl #(
      .WIRQ(2), .GAP_CYC(4), .TIMEOUT_CYC(8), .CNT_W(2)
   ) dut (
      .axi_aclk    (clk),
      .axi_aresetn (rst_n),
      .irq_event   (ev),
      .irq_mask    (msk),
      .usr_irq_req (req),
      .usr_irq_ack (ack),
      .irq_pending (pend),
      .irq_busy    (busy),
      .irq_err     (err),
      .err_clr     (clr),
      .irq_sent_cnt(cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      ev = '0; msk = '0; ack = '0; clr = '0;
      tick(2);
      rst_n = 1'b1;
   endtask

   initial begin
      int  since, low, acks, exp_cnt;
      bit  prev, seen;

      // reset state
      do_reset();
      rst_n = 1'b0;
      #1;
      chk("rst_req", req, 0);
      chk("rst_pend", pend, 0);
      chk("rst_busy", busy, 0);
      chk("rst_err", err, 0);
      chk("rst_cnt", cnt, 0);
      tick(1);
      rst_n = 1'b1;

      // 1: single event, ack, gap
      ev = 2'b01;
      tick();
      ev = 2'b00;
      chk("t1_pend", pend, 2'b01);
      chk("t1_req_lat1", req, 0);
      tick();
      chk("t1_req_rise", req, 2'b01);
      chk("t1_pend_clr", pend, 0);
      tick(2);
      chk("t1_req_hold", req, 2'b01);
      ack = 2'b01;
      tick();
      ack = 2'b00;
      chk("t1_req_fall", req, 0);
      chk("t1_cnt", cnt, 1);
      tick(3);
      chk("t1_gap_busy", busy, 2'b01);
      tick();
      chk("t1_idle", busy, 0);
      chk("t1_err", err, 0);

      // 3: timeout after 8 request cycles
      ev = 2'b01;
      tick();
      ev = 2'b00;
      tick();
      chk("t3_req_rise", req, 2'b01);
      tick(7);
      chk("t3_req_8th", req, 2'b01);
      chk("t3_err_pre", err, 0);
      tick();
      chk("t3_req_drop", req, 0);
      chk("t3_err_set", err, 2'b01);
      chk("t3_cnt", cnt, 1);
      clr = 2'b01;
      tick();
      clr = 2'b00;
      chk("t3_err_clr", err, 0);
      tick(4);
      chk("t3_idle", busy, 0);

      // 4: mask gating
      msk = 2'b01;
      ev  = 2'b01;
      tick();
      ev  = 2'b00;
      chk("t4_pend", pend, 2'b01);
      tick(3);
      chk("t4_no_req", req, 0);
      chk("t4_pend_keep", pend, 2'b01);
      msk = 2'b00;
      tick();
      chk("t4_req_unmask", req, 2'b01);
      chk("t4_pend_clr", pend, 0);
      msk = 2'b01;
      tick(2);
      chk("t4_req_masked", req, 2'b01);
      ack = 2'b01;
      tick();
      ack = 2'b00;
      chk("t4_req_fall", req, 0);
      chk("t4_cnt", cnt, 2);
      tick(5);
      chk("t4_idle", busy, 0);
      msk = 2'b00;

      // 2: event[1] held, ack 3 cycles after each rise
      do_reset();
      since = -1; low = 0; acks = 0; prev = 0; seen = 0;
      for (int i = 0; i < 45; i++) begin
         ev[1]  = (i < 20);
         ack[1] = (since == 3);
         if (since == 3) acks++;
         tick();
         if (req[1]) begin
            if (!prev) begin
               if (seen) chk("t2_gap_low", (low >= 5), 1);
               low   = 0;
               since = 0;
            end else begin
               since++;
            end
         end else begin
            if (prev) seen = 1;
            low++;
            since = -1;
         end
         prev = req[1];
      end
      ack = '0;
      ev  = '0;
      exp_cnt = (acks > 3) ? 3 : acks;
      chk("t2_acks", (acks >= 3), 1);
      chk("t2_cnt", cnt, exp_cnt);
      chk("t2_pend_end", pend, 0);
      chk("t2_req_end", req, 0);

      // 5: saturation, gap acks, idle acks
      do_reset();
      ack = 2'b11;
      tick();
      ack = 2'b00;
      chk("t5_idle_ack", cnt, 0);
      ev = 2'b11;
      tick();
      ev = 2'b00;
      tick();
      chk("t5_req_both", req, 2'b11);
      ack = 2'b11;
      tick();
      chk("t5_cnt2", cnt, 2);
      tick();
      ack = 2'b00;
      chk("t5_gap_ack", cnt, 2);
      tick(5);
      ev = 2'b11;
      tick();
      ev = 2'b00;
      tick();
      ack = 2'b11;
      tick();
      ack = 2'b00;
      chk("t5_sat", cnt, 3);
      tick(5);
      ev = 2'b11;
      tick();
      ev = 2'b00;
      tick();
      ack = 2'b11;
      tick();
      ack = 2'b00;
      chk("t5_sat_hold", cnt, 3);
      tick(5);

      // 6: async reset mid-REQ
      ev = 2'b01;
      tick();
      ev = 2'b00;
      tick();
      chk("t6_req_pre", req, 2'b01);
      #2 rst_n = 1'b0;
      #1;
      chk("t6_req_async", req, 0);
      chk("t6_busy", busy, 0);
      chk("t6_cnt", cnt, 0);
      chk("t6_pend", pend, 0);
      tick();
      rst_n = 1'b1;
      tick();
      chk("t6_idle", req, 0);
      ev = 2'b01;
      tick();
      ev = 2'b00;
      chk("t6_pend_new", pend, 2'b01);
      chk("t6_req_lat", req, 0);
      tick();
      chk("t6_req_new", req, 2'b01);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/xdma_irq_ctrl.md
Name: xdma_irq_ctrl

Overview:
- Sequences the XDMA user-interrupt handshake (usr_irq_req/usr_irq_ack) on behalf of application logic such as the GPIO/LED and AXI RAM blocks.
- Latches per-vector event pulses into pending bits and drives one request per vector.
- Holds each request until the core acknowledges it, then enforces a minimum gap before the next request on that vector.
- Detects missing acknowledges with a timeout and keeps a saturating count of delivered interrupts. Sits between user logic and the xdma_mcap_top usr_irq ports in the axi_aclk domain.

Parameters:
- WIRQ, 2, number of interrupt vectors (1..16).
- GAP_CYC, 4, cycles usr_irq_req stays low after an ack or timeout before the vector may re-request (>=1).
- TIMEOUT_CYC, 1024, max cycles in REQ without ack before abort; 0 disables the timeout.
- CNT_W, 16, width of the delivered-interrupt counter.

Ports:
- axi_aclk  in  1  clock.
- axi_aresetn  in  1  reset; asynchronous, active-low.
- irq_event  in  WIRQ  per-vector event; each cycle high sets that vector's pending bit.
- irq_mask  in  WIRQ  1 = vector may not start a new request.
- usr_irq_req  out  WIRQ  to XDMA core; registered.
- usr_irq_ack  in  WIRQ  from XDMA core; single-cycle ack pulses.
- irq_pending  out  WIRQ  pending bits (registered).
- irq_busy  out  WIRQ  1 while the vector is in REQ or GAP.
- irq_err  out  WIRQ  sticky timeout flag per vector.
- err_clr  in  WIRQ  clears the corresponding irq_err bit.
- irq_sent_cnt  out  CNT_W  total acknowledged interrupts, saturating.

Behaviour:
- **Reset** (axi_aresetn=0, async): all FSMs go to IDLE. usr_irq_req, irq_pending, irq_busy, irq_err are 0. irq_sent_cnt=0. Internal counters are 0.
- **Reset mid-REQ:** usr_irq_req drops immediately (asynchronously). The pending event is lost.
- **Per-vector FSM**, independent for each i:
  - IDLE: if pending[i] & ~mask[i], go to REQ at the next edge. In the same edge, pending[i] clears, unless irq_event[i]=1 that cycle (set wins over clear).
  - REQ: usr_irq_req[i]=1. Timeout counter increments each cycle.
    - usr_irq_ack[i]=1 → GAP at the next edge; usr_irq_req[i]=0 from then on.
    - Else if TIMEOUT_CYC!=0 and counter reaches TIMEOUT_CYC-1 → GAP; irq_err[i] set.
  - GAP: usr_irq_req[i]=0. Counts GAP_CYC cycles, then IDLE. Acks in GAP are ignored; they are neither counted nor treated as errors. This covers the second ack the core issues on deassert.
- **Latency:**
  - Event high in cycle n: pending=1 in n+1, usr_irq_req=1 in n+2 (vector idle, unmasked).
  - Ack in cycle m: req=0 in m+1, GAP spans m+1..m+GAP_CYC, IDLE in m+GAP_CYC+1. The earliest re-request is m+GAP_CYC+2.
- **Event rules:**
  - An event while in REQ/GAP sets pending and produces exactly one further request after GAP.
  - Multiple events before capture coalesce into one request.
- **Mask rules:**
  - Mask only gates the IDLE→REQ transition. Setting the mask during REQ/GAP does not abort the handshake.
  - Pending still accumulates while masked.
- **Errors:** irq_err[i] is sticky until err_clr[i]=1. If a new timeout and err_clr coincide, set wins.
- **Counter:**
  - irq_sent_cnt adds the popcount of (usr_irq_ack & state==REQ) each cycle. Timeouts are not counted.
  - Saturates at 2^CNT_W-1; simultaneous acks that would exceed the limit clamp.
- **Other outputs and defaults:**
  - irq_busy[i] = (state != IDLE), registered with state.
  - Ack on a vector in IDLE is ignored.

Test Plan:
1. Reset, WIRQ=2, GAP_CYC=4. Pulse irq_event[0] in cycle 10, ack[0] in cycle 15 → req[0] high cycles 12-15, low from 16. Vector returns to IDLE at cycle 20, cnt=1, err=0.
2. irq_event[1] held high for cycles 10-30, ack[1] returned 3 cycles after each req rise → periodic requests, each with ≥4 low cycles between them; cnt equals the number of acks; pending[1] ends at 0 one cycle after the event drops and the final capture occurs.
3. TIMEOUT_CYC=8, event[0], never ack → req[0] high exactly 8 cycles, then low; irq_err[0]=1, cnt unchanged. err_clr[0] pulse → err=0.
4. mask[0]=1, event[0] → pending[0]=1, no req. Clear mask at cycle 40 → req[0] rises cycle 41. Mask set during REQ → handshake completes normally on ack.
5. Both vectors acked in the same cycle with CNT_W=2, cnt=2 → cnt=3 (saturated), then stays 3 on further acks. Ack during GAP → cnt unchanged.
6. Assert axi_aresetn=0 mid-REQ → usr_irq_req=0 without a clock edge, all status outputs 0. After release, a fresh event produces a normal 2-cycle-latency request.
